mbist_march_ctrl: RTL and testbench

March C- built-in self-test controller that acts as the initiator for the 64x8 single-port `sram` block. It drives `ramaddr`/`ramin`/`rwbar`/`cs`, checks `ramout` against the expected data background and reports pass/fail with first-failure diagnostics. It sits between the test-access/top-level control and the memory under test, and is the only master of the SRAM port while `busy` is high.

---
 rtl/mbist_pkg.sv | 42 ++++
 rtl/mbist_addr_gen.sv | 41 ++++
 rtl/mbist_march_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// Shared types and March C- element table for the MBIST controller.
package mbist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CHECK,
    WR,
    DONE
  } mbist_state_e;

  localparam int unsigned MARCH_ELEMS = 6;

  typedef struct packed {
    logic dir_down;
    logic rd_en;
    logic rd_val;
    logic wr_en;
    logic wr_val;
  } march_elem_t;

  localparam march_elem_t ELEM_0 = '{dir_down: 1'b0, rd_en: 1'b0, rd_val: 1'b0, wr_en: 1'b1, wr_val: 1'b0};
  localparam march_elem_t ELEM_1 = '{dir_down: 1'b0, rd_en: 1'b1, rd_val: 1'b0, wr_en: 1'b1, wr_val: 1'b1};
  localparam march_elem_t ELEM_2 = '{dir_down: 1'b0, rd_en: 1'b1, rd_val: 1'b1, wr_en: 1'b1, wr_val: 1'b0};
  localparam march_elem_t ELEM_3 = '{dir_down: 1'b1, rd_en: 1'b1, rd_val: 1'b0, wr_en: 1'b1, wr_val: 1'b1};
  localparam march_elem_t ELEM_4 = '{dir_down: 1'b1, rd_en: 1'b1, rd_val: 1'b1, wr_en: 1'b1, wr_val: 1'b0};
  localparam march_elem_t ELEM_5 = '{dir_down: 1'b0, rd_en: 1'b1, rd_val: 1'b0, wr_en: 1'b0, wr_val: 1'b0};

  // Indices past the last element decode to an all-zero (no-op) entry.
  function automatic march_elem_t march_elem(input logic [2:0] idx);
    case (idx)
      3'd0:    return ELEM_0;
      3'd1:    return ELEM_1;
      3'd2:    return ELEM_2;
      3'd3:    return ELEM_3;
      3'd4:    return ELEM_4;
      3'd5:    return ELEM_5;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for March elements; load selects the start end
// (0 or DEPTH-1) and last flags the terminal address for the current direction.
module mbist_addr_gen #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              load_down_i,
  input  logic              adv_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? TOP_ADDR : '0;
    end else if (adv_i) begin
      addr_d = down_i ? addr_q - 1'b1 : addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = down_i ? (addr_q == '0) : (addr_q == TOP_ADDR);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller driving a single-port SRAM with first-fail capture.
// Optional: define MBIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramin,
  output logic              rwbar,
  output logic              cs,
  input  logic [DATA_W-1:0] ramout
);

  mbist_state_e      state_q, state_d;
  logic [2:0]        elem_q, elem_d, elem_nxt;
  logic              busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic [DATA_W-1:0] ramin_q, ramin_d;
  logic              rwbar_q, rwbar_d, cs_q, cs_d;
  logic              ld, ld_down, adv, addr_last, step_addr, mismatch;
  logic [ADDR_W-1:0] addr;

  mbist_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (ld),
    .load_down_i (ld_down),
    .adv_i       (adv),
    .down_i      (march_elem(elem_q).dir_down),
    .addr_o      (addr),
    .last_o      (addr_last)
  );

  assign elem_nxt = elem_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_elem_d = fail_elem_q;
    ld          = 1'b0;
    ld_down     = 1'b0;
    adv         = 1'b0;
    step_addr   = 1'b0;
    mismatch    = (state_q == RD_CHECK) &&
                  (ramout != {DATA_W{march_elem(elem_q).rd_val}});

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = WR;
          elem_d      = '0;
          ld          = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          fail_elem_d = '0;
        end
      end
      RD_ISSUE: state_d = RD_CHECK;
      RD_CHECK: begin
        if (mismatch) begin
          fail_d = 1'b1;
          if (!fail_q) begin
            fail_addr_d = addr;
            fail_data_d = ramout;
            fail_elem_d = elem_q;
          end
        end
        if (march_elem(elem_q).wr_en) state_d = WR;
        else                          step_addr = 1'b1;
      end
      WR:      step_addr = 1'b1;
      default: state_d = IDLE;
    endcase

    // Last op at this address done: advance, roll into next element, or finish.
    if (step_addr) begin
      if (!addr_last) begin
        adv     = 1'b1;
        state_d = march_elem(elem_q).rd_en ? RD_ISSUE : WR;
      end else if (elem_q == 3'(MARCH_ELEMS - 1)) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        elem_d  = elem_nxt;
        ld      = 1'b1;
        ld_down = march_elem(elem_nxt).dir_down;
        state_d = march_elem(elem_nxt).rd_en ? RD_ISSUE : WR;
      end
    end

`ifdef MBIST_STOP_ON_FAIL_EN
    if (mismatch) begin
      state_d = DONE;
      done_d  = 1'b1;
      elem_d  = elem_q;
      ld      = 1'b0;
      adv     = 1'b0;
    end
`endif

    busy_d  = (state_d == RD_ISSUE) || (state_d == RD_CHECK) || (state_d == WR);
    cs_d    = busy_d;
    rwbar_d = (state_d != WR);
    ramin_d = (state_d == WR) ? {DATA_W{march_elem(elem_d).wr_val}} : ramin_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= '0;
      ramin_q     <= '0;
      rwbar_q     <= 1'b1;
      cs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_elem_q <= fail_elem_d;
      ramin_q     <= ramin_d;
      rwbar_q     <= rwbar_d;
      cs_q        <= cs_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign fail_elem = fail_elem_q;
  assign ramaddr   = addr;
  assign ramin     = ramin_q;
  assign rwbar     = rwbar_q;
  assign cs        = cs_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl with a behavioural 64x8 SRAM and an
// optional stuck-at-1 on bit 3 of address 5.
module tb_mbist_march_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic       busy, done, fail, rwbar, cs;
  logic [5:0] fail_addr, ramaddr;
  logic [7:0] fail_data, ramin, ramout;
  logic [2:0] fail_elem;

  logic [7:0] mem [64];
  logic       fault_en = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [5:0] addr_log [1024];
  logic       rw_log   [1024];
  logic       fail_log [1024];

  always #5 clk = ~clk;

  mbist_march_ctrl #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .fail_elem (fail_elem),
    .ramaddr   (ramaddr),
    .ramin     (ramin),
    .rwbar     (rwbar),
    .cs        (cs),
    .ramout    (ramout)
  );

  initial ramout = 8'h00;

  always @(posedge clk) begin
    if (cs) begin
      if (!rwbar) mem[ramaddr] <= ramin;
      else        ramout <= mem[ramaddr] | ((fault_en && ramaddr == 6'd5) ? 8'h08 : 8'h00);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(output int cyc, output int cs_cnt);
    cyc = 0;
    cs_cnt = cs ? 1 : 0;
    addr_log[0] = ramaddr; rw_log[0] = rwbar; fail_log[0] = fail;
    while (done !== 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
      if (cs) cs_cnt++;
      if (cyc < 1024) begin
        addr_log[cyc] = ramaddr; rw_log[cyc] = rwbar; fail_log[cyc] = fail;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, done, fail, cs, rwbar} !== 5'b00001) begin
      failures++; $display("FAIL reset_ctl got %b want 00001", {busy, done, fail, cs, rwbar});
    end
    checks++;
    if ({fail_addr, fail_data, fail_elem, ramaddr, ramin} !== '0) begin
      failures++; $display("FAIL reset_data got %h/%h/%h/%h/%h want all zero",
                           fail_addr, fail_data, fail_elem, ramaddr, ramin);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fault_free();
    int cyc, cs_cnt;
    fault_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({busy, cs, rwbar, ramaddr, ramin} !== {1'b1, 1'b1, 1'b0, 6'd0, 8'h00}) begin
      failures++; $display("FAIL first_op got busy=%b cs=%b rwbar=%b addr=%0d din=%h want 1 1 0 0 00",
                           busy, cs, rwbar, ramaddr, ramin);
    end
    run_until_done(cyc, cs_cnt);
    checks++;
    if (cyc !== 960) begin failures++; $display("FAIL run_len got %0d want 960", cyc); end
    checks++;
    if (cs_cnt !== 960) begin failures++; $display("FAIL cs_cycles got %0d want 960", cs_cnt); end
    checks++;
    if ({done, busy, cs, fail} !== 4'b1000) begin
      failures++; $display("FAIL end_state got done/busy/cs/fail=%b want 1000", {done, busy, cs, fail});
    end
  endtask

  task automatic test_addr_order();
    int bad;
    checks++;
    if (addr_log[448] !== 6'd63 || rw_log[448] !== 1'b1) begin
      failures++; $display("FAIL e3_first got addr=%0d rwbar=%b want 63 1", addr_log[448], rw_log[448]);
    end
    checks++;
    if (addr_log[639] !== 6'd0 || rw_log[639] !== 1'b0) begin
      failures++; $display("FAIL e3_last got addr=%0d rwbar=%b want 0 0", addr_log[639], rw_log[639]);
    end
    bad = 0;
    for (int n = 832; n < 960; n++) begin
      if (rw_log[n] !== 1'b1 || addr_log[n] !== 6'((n - 832) / 2)) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL e5_ascend got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_fault();
    int cyc, cs_cnt;
    fault_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    run_until_done(cyc, cs_cnt);
`ifdef MBIST_STOP_ON_FAIL_EN
    checks++;
    if (cyc !== 81) begin failures++; $display("FAIL stop_len got %0d want 81", cyc); end
`else
    checks++;
    if (cyc !== 960) begin failures++; $display("FAIL fault_len got %0d want 960", cyc); end
`endif
    checks++;
    if (fail_log[80] !== 1'b0 || fail_log[81] !== 1'b1) begin
      failures++; $display("FAIL fail_edge got @80=%b @81=%b want 0 1", fail_log[80], fail_log[81]);
    end
    checks++;
    if ({fail, fail_addr, fail_data, fail_elem} !== {1'b1, 6'd5, 8'h08, 3'd1}) begin
      failures++; $display("FAIL diag got fail=%b addr=%0d data=%h elem=%0d want 1 5 08 1",
                           fail, fail_addr, fail_data, fail_elem);
    end
    checks++;
    if ({done, busy, cs} !== 3'b100) begin
      failures++; $display("FAIL fault_end got done/busy/cs=%b want 100", {done, busy, cs});
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, cs_cnt;
    fault_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 400; n++) tick();
    checks++;
    if (fail !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL pre_reset got fail=%b busy=%b want 1 1", fail, busy);
    end
    rst_n = 1'b0; tick();
    checks++;
    if ({busy, cs, done, fail, rwbar, ramaddr} !== {5'b00001, 6'd0}) begin
      failures++; $display("FAIL mid_reset got busy/cs/done/fail/rwbar=%b addr=%0d want 00001 0",
                           {busy, cs, done, fail, rwbar}, ramaddr);
    end
    rst_n = 1'b1; fault_en = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    run_until_done(cyc, cs_cnt);
    checks++;
    if (cyc !== 960 || fail !== 1'b0) begin
      failures++; $display("FAIL post_reset_run got len=%0d fail=%b want 960 0", cyc, fail);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, cs_cnt;
    fault_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    run_until_done(cyc, cs_cnt);
    fault_en = 1'b0;
    start = 1'b1; tick();
    checks++;
    if ({done, fail, busy, cs, rwbar, ramaddr, ramin, fail_addr, fail_elem}
        !== {5'b00110, 6'd0, 8'h00, 6'd0, 3'd0}) begin
      failures++; $display("FAIL restart got done/fail/busy/cs/rwbar=%b addr=%0d din=%h faddr=%0d felem=%0d",
                           {done, fail, busy, cs, rwbar}, ramaddr, ramin, fail_addr, fail_elem);
    end
    run_until_done(cyc, cs_cnt);
    checks++;
    if (cyc !== 960) begin failures++; $display("FAIL held_start_len got %0d want 960", cyc); end
    tick();
    checks++;
    if ({done, busy, rwbar, ramaddr} !== {3'b010, 6'd0}) begin
      failures++; $display("FAIL rerestart got done/busy/rwbar=%b addr=%0d want 010 0",
                           {done, busy, rwbar}, ramaddr);
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_addr_order();
    test_fault();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
